alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Parametrised, handshaked ALU and the successor to the single-cycle RV32I ALU.
//   It executes the same RV-I op set with one registered cycle of latency.
//   It adds the RV-M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) using an
//   iterative shift-add multiplier and a restoring divider, one bit per cycle.
//   It sits between decode and writeback; the core stalls on in_ready/out_valid.
// PARAMETERS
//   XLEN   32   operand/result width; must be >= 8 and a power of two.
//   SHW    $clog2(XLEN)   localparam: shift-amount width, derived, not overridable.
// PORTS
//   clk        in   1     single clock; all state updates on its rising edge.
//   rst_n      in   1     synchronous, active-low reset.
//   in_valid   in   1     op/rv1/rv2 are valid this cycle.
//   in_ready   out  1     block accepts an op this cycle (transfer = in_valid & in_ready).
//   op         in   6     op[5]=0: base op on op[4:0]; op[5]=1: M op on op[2:0] = funct3.
//   rv1        in   XLEN  first operand.
//   rv2        in   XLEN  second operand.
//   out_valid  out  1     rvout holds a completed result.
//   out_ready  in   1     consumer takes the result (transfer = out_valid & out_ready).
//   rvout      out  XLEN  result; registered, held stable while out_valid & !out_ready.
// BEHAVIOUR
//   Base op codes (op[5]=0, op[4:0]):
//     01000 ADD    11000 SUB    01001 SLL    01010 SLT (signed)    01011 SLTU
//     01100 XOR    01101 SRL    11101 SRA    01110 OR              01111 AND
//     Any other code: result 0.
//     Shifts use rv2[SHW-1:0] only. SLT/SLTU produce a zero-extended 1 or 0.
//   M op codes (op[5]=1, op[4:3] ignored):
//     000 MUL   001 MULH   010 MULHSU   011 MULHU
//     100 DIV   101 DIVU   110 REM      111 REMU
//     MUL returns the low XLEN bits; MULH* return the high XLEN bits of the 2*XLEN product.
//     Signed M ops work on magnitudes and apply the sign fix at the end.
//     DIV/REM round toward zero; the remainder takes the sign of the dividend.
//   FSM states: IDLE, CALC, DONE. in_ready = (state==IDLE) & rst_n.
//   IDLE, on accept:
//     base op, div-by-zero or signed overflow: result computed and registered -> DONE.
//       Latency 1: out_valid is high the cycle after accept.
//     other M op: operands loaded, count=XLEN -> CALC.
//   CALC: one iteration per cycle; count decrements. At count==1 the fixed-up result
//     is registered -> DONE. Latency XLEN+1 cycles from accept to out_valid.
//   DONE: out_valid=1. If out_ready, out_valid drops next cycle -> IDLE.
//     in_valid is ignored outside IDLE. Minimum issue interval is 2 cycles.
//   Special cases, all fast path (latency 1):
//     divide by zero: DIV/DIVU = all ones; REM/REMU = rv1.
//     signed overflow (DIV of -2^(XLEN-1) by -1): DIV = -2^(XLEN-1); REM = 0.
//   Reset (rst_n=0 at a clock edge):
//     state=IDLE, out_valid=0, rvout=0, count=0.
//     An op in flight is abandoned with no output. in_ready=0 while rst_n=0.
//   Operands are captured at accept; changes to rv1/rv2/op after accept have no effect.
//   No X on rvout in any reachable state.
// TESTING (XLEN=32)
//   1. ADD 5,7 -> rvout=12, out_valid 1 cycle after accept.
//      SRA 0x80000000,4 -> 0xF8000000.  SLT 0xFFFFFFFF,1 -> 1.  SLTU 0xFFFFFFFF,1 -> 0.
//   2. MUL 0xFFFFFFFF,2 -> 0xFFFFFFFE;  MULH 0xFFFFFFFF,2 -> 0xFFFFFFFF;
//      MULHU 0xFFFFFFFF,2 -> 0x00000001;  MULHSU 0xFFFFFFFF,2 -> 0xFFFFFFFF.
//      out_valid exactly 33 cycles after accept.
//   3. DIV 0xFFFFFFF9,2 -> 0xFFFFFFFD;  REM 0xFFFFFFF9,2 -> 0xFFFFFFFF;
//      DIVU 100,7 -> 14;  REMU 100,7 -> 2.
//   4. DIVU 10,0 -> 0xFFFFFFFF;  REM 10,0 -> 10;
//      DIV 0x80000000,0xFFFFFFFF -> 0x80000000;  REM of same -> 0.  All with latency 1.
//   5. out_ready held low 5 cycles in DONE -> rvout and out_valid stable, in_ready=0,
//      in_valid pulses ignored. Result consumed on the cycle out_ready rises.
//   6. rst_n low for 1 cycle mid-CALC of DIVU -> next cycle out_valid=0, rvout=0, state IDLE.
//      A following ADD 1,1 -> 2 with latency 1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked RV32I/RV-M ALU with single-cycle base ops and iterative multiply/divide
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      op,
    input  logic [XLEN-1:0] rv1,
    input  logic [XLEN-1:0] rv2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rvout
);
    localparam int SHW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state;
    logic [SHW:0] count;
    logic [2:0] fn;
    logic neg;
    logic [XLEN-1:0] opa;
    logic [2*XLEN-1:0] acc;
    logic [2:0] f;
    logic [SHW-1:0] sh;
    logic [XLEN-1:0] base_res, fast_res, mag1, mag2, q, r, dv, calc_res;
    logic a_neg, b_neg, dz, ovf, fast, ge;
    logic [XLEN:0] sum, rsh, diff;
    logic [2*XLEN-1:0] acc_n, mul_p;
    assign in_ready = (state == IDLE) & rst_n;
    always_comb begin
        f = op[2:0];
        sh = rv2[SHW-1:0];
        case (op[4:0])
            5'b01000: base_res = rv1 + rv2;
            5'b11000: base_res = rv1 - rv2;
            5'b01001: base_res = rv1 << sh;
            5'b01010: base_res = {{(XLEN-1){1'b0}}, $signed(rv1) < $signed(rv2)};
            5'b01011: base_res = {{(XLEN-1){1'b0}}, rv1 < rv2};
            5'b01100: base_res = rv1 ^ rv2;
            5'b01101: base_res = rv1 >> sh;
            5'b11101: base_res = $unsigned($signed(rv1) >>> sh);
            5'b01110: base_res = rv1 | rv2;
            5'b01111: base_res = rv1 & rv2;
            default:  base_res = '0;
        endcase
        a_neg = rv1[XLEN-1] & (f[2] ? !f[0] : (f[0] ^ f[1]));
        b_neg = rv2[XLEN-1] & (f[2] ? !f[0] : (f[1:0] == 2'b01));
        dz = rv2 == '0;
        ovf = !f[0] & (rv1 == {1'b1, {(XLEN-1){1'b0}}}) & (&rv2);
        fast = !op[5] | (f[2] & (dz | ovf));
        fast_res = !op[5] ? base_res : dz ? (f[1] ? rv1 : '1) : (f[1] ? '0 : rv1);
        mag1 = a_neg ? -rv1 : rv1;
        mag2 = b_neg ? -rv2 : rv2;
        sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? opa : '0};
        rsh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff = rsh - {1'b0, opa};
        ge = !diff[XLEN];
        acc_n = fn[2] ? {ge ? diff[XLEN-1:0] : rsh[XLEN-1:0], acc[XLEN-2:0], ge}
                      : {sum, acc[XLEN-1:1]};
        mul_p = neg ? -acc_n : acc_n;
        q = acc_n[XLEN-1:0];
        r = acc_n[2*XLEN-1:XLEN];
        dv = fn[1] ? r : q;
        calc_res = !fn[2] ? (fn[1:0] == 2'b00 ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN])
                          : (neg ? -dv : dv);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            out_valid <= 1'b0;
            rvout <= '0;
            count <= '0;
            fn <= '0;
            neg <= 1'b0;
            opa <= '0;
            acc <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    fn <= f;
                    if (fast) begin
                        rvout <= fast_res;
                        out_valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        neg <= (f[2] & f[1]) ? a_neg : (a_neg ^ b_neg);
                        opa <= f[2] ? mag2 : mag1;
                        acc <= {{XLEN{1'b0}}, f[2] ? mag1 : mag2};
                        count <= (SHW+1)'(XLEN);
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_n;
                    count <= count - 1'b1;
                    if (count == (SHW+1)'(1)) begin
                        rvout <= calc_res;
                        out_valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq covering base ops, RV-M ops, stalls and reset
module tb_alu_seq;
    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid;
    logic [5:0] op = '0;
    logic [31:0] rv1 = '0, rv2 = '0, rvout;
    int n_chk = 0, n_fail = 0;
    logic [31:0] exp_q[$];
    localparam logic [5:0] ADD = 6'b001000, SUB = 6'b011000, SLL = 6'b001001, SLT = 6'b001010,
        SLTU = 6'b001011, XOR = 6'b001100, SRL = 6'b001101, SRA = 6'b011101, OR = 6'b001110,
        AND = 6'b001111, MUL = 6'b100000, MULH = 6'b100001, MULHSU = 6'b100010,
        MULHU = 6'b100011, DIV = 6'b100100, DIVU = 6'b100101, REM = 6'b100110, REMU = 6'b100111;

    alu_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rv1(rv1), .rv2(rv2), .out_valid(out_valid), .out_ready(out_ready), .rvout(rvout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub;
        logic [63:0] p;
        logic ov;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        ov = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFFFFFF : ov ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: return (b == 0) ? a : ov ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic issue(input string tag, input logic [5:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] exp);
        int n;
        @(negedge clk);
        in_valid = 1; op = o; rv1 = a; rv2 = b;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 0; op = 6'($urandom); rv1 = $urandom; rv2 = $urandom;
        n = 1;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check(tag, rvout, exp_q.pop_front());
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run(input string tag, input logic [5:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic [31:0] exp);
        issue(tag, o, a, b, lat, exp);
        consume(tag);
    endtask

    initial begin
        logic [31:0] hold, a, b;
        logic [2:0] f;
        int lat;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_rvout", rvout, 0);
        check("rst_in_ready", 32'(in_ready), 0);
        @(negedge clk) rst_n = 1;

        run("add", ADD, 5, 7, 1, 12);
        run("sub", SUB, 5, 7, 1, 32'hFFFFFFFE);
        run("sll", SLL, 32'h1, 32'h21, 1, 32'h2);
        run("sra", SRA, 32'h80000000, 4, 1, 32'hF8000000);
        run("srl", SRL, 32'h80000000, 4, 1, 32'h08000000);
        run("slt", SLT, 32'hFFFFFFFF, 1, 1, 1);
        run("sltu", SLTU, 32'hFFFFFFFF, 1, 1, 0);
        run("xor", XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 1, 32'hFF00_EDCB);
        run("or", OR, 32'hF000_0001, 32'h0000_1000, 1, 32'hF000_1001);
        run("and", AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 32'h0F00_0F00);
        run("bad_op", 6'b000000, 3, 4, 1, 0);

        run("mul", MUL, 32'hFFFFFFFF, 2, 33, 32'hFFFFFFFE);
        run("mulh", MULH, 32'hFFFFFFFF, 2, 33, 32'hFFFFFFFF);
        run("mulhu", 6'b111011, 32'hFFFFFFFF, 2, 33, 32'h00000001);
        run("mulhsu", MULHSU, 32'hFFFFFFFF, 2, 33, 32'hFFFFFFFF);
        run("div", DIV, 32'hFFFFFFF9, 2, 33, 32'hFFFFFFFD);
        run("rem", REM, 32'hFFFFFFF9, 2, 33, 32'hFFFFFFFF);
        run("divu", DIVU, 100, 7, 33, 14);
        run("remu", REMU, 100, 7, 33, 2);

        run("divu_z", DIVU, 10, 0, 1, 32'hFFFFFFFF);
        run("rem_z", REM, 10, 0, 1, 10);
        run("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
        run("rem_ovf", REM, 32'h80000000, 32'hFFFFFFFF, 1, 0);

        for (int i = 0; i < 12; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 5 == 0) a = -a;
            lat = (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 33;
            run($sformatf("rand%0d_f%0d", i, f), {3'b100, f}, a, b, lat, m_model(f, a, b));
        end

        issue("stall", XOR, 32'h1234_5678, 32'hFFFF_0000, 1, 32'hEDCB_5678);
        hold = rvout;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0); op = ADD; rv1 = $urandom; rv2 = $urandom;
            @(posedge clk); #1;
            check($sformatf("stall_rv%0d", i), rvout, hold);
            check($sformatf("stall_ov%0d", i), 32'(out_valid), 1);
            check($sformatf("stall_rdy%0d", i), 32'(in_ready), 0);
        end
        @(negedge clk) in_valid = 0;
        consume("stall");
        run("after_stall", ADD, 9, 1, 1, 10);

        @(negedge clk);
        in_valid = 1; op = DIVU; rv1 = 1000; rv2 = 3;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 0;
        @(posedge clk); #1;
        check("midrst_ov", 32'(out_valid), 0);
        check("midrst_rv", rvout, 0);
        check("midrst_rdy_low", 32'(in_ready), 0);
        @(negedge clk) rst_n = 1;
        #1 check("midrst_rdy", 32'(in_ready), 1);
        repeat (40) @(posedge clk);
        #1 check("midrst_abandon", 32'(out_valid), 0);
        run("post_rst_add", ADD, 1, 1, 1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
